// File: rtl/prbs9_pkg.sv
// Shared PRBS9 constants: polynomial taps, FSM encodings and checker defaults.
// The prbs9 transmitter uses the same tap indices.
package prbs9_pkg;
    localparam int PRBS9_LEN      = 9;
    localparam int TAP_A          = 8;
    localparam int TAP_B          = 4;
    localparam int VERIFY_LEN_DEF = 64;
    localparam int WIN_LEN_DEF    = 128;
    localparam int LOSS_THR_DEF   = 16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs9_state_e;

    // Next PRBS9 bit from the last nine bits, s[0] newest (x^9 + x^5 + 1).
    function automatic logic prbs9_predict(input logic [PRBS9_LEN-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction
endpackage

// File: rtl/prbs9_ber_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
module sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/prbs9_ber_checker.sv
// Self-synchronising PRBS9 receiver with lock detection and BER counters.
//   state     | meaning
//   ST_LOAD   | filling the local LFSR with the first nine received bits
//   ST_VERIFY | checking predictions; VERIFY_LEN clean bits in a row declare lock
//   ST_LOCKED | counting bits/errors; LOSS_THR errors in one window force relock
module prbs9_ber_checker
    import prbs9_pkg::*;
#(
    parameter int NB_COUNT   = 64,
    parameter int VERIFY_LEN = VERIFY_LEN_DEF,
    parameter int WIN_LEN    = WIN_LEN_DEF,
    parameter int LOSS_THR   = LOSS_THR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic                i_bit,
    input  logic                i_clear,
    output logic                o_locked,
    output logic [1:0]          o_state,
    output logic [NB_COUNT-1:0] o_bit_count,
    output logic [NB_COUNT-1:0] o_error_count,
    output logic                o_ber_zero
);
    localparam int LW = $clog2(PRBS9_LEN);
    localparam int VW = $clog2(VERIFY_LEN + 1);
    localparam int WW = $clog2(WIN_LEN + 1);

    prbs9_state_e         state, state_n;
    logic [PRBS9_LEN-1:0] lfsr;
    logic [LW-1:0]        load_cnt, load_cnt_n;
    logic [VW-1:0]        verify_cnt, verify_cnt_n;
    logic [WW-1:0]        win_bits, win_bits_n;
    logic [WW-1:0]        win_errs, win_errs_n;
    logic                 consume, mismatch, count_bit, count_err;
    logic                 locked;

    assign consume  = i_valid && i_enable;
    assign mismatch = i_bit ^ prbs9_predict(lfsr);

    always_comb begin
        state_n      = state;
        load_cnt_n   = load_cnt;
        verify_cnt_n = verify_cnt;
        win_bits_n   = win_bits;
        win_errs_n   = win_errs;
        count_bit    = 1'b0;
        count_err    = 1'b0;
        if (consume) begin
            case (state)
                ST_LOAD: begin
                    if (load_cnt == LW'(PRBS9_LEN - 1)) begin
                        state_n      = ST_VERIFY;
                        load_cnt_n   = '0;
                        verify_cnt_n = '0;
                    end else begin
                        load_cnt_n = load_cnt + LW'(1);
                    end
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        state_n    = ST_LOAD;
                        load_cnt_n = '0;
                    end else if (verify_cnt == VW'(VERIFY_LEN - 1)) begin
                        state_n    = ST_LOCKED;
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end else begin
                        verify_cnt_n = verify_cnt + VW'(1);
                    end
                end
                ST_LOCKED: begin
                    count_bit  = 1'b1;
                    count_err  = mismatch;
                    win_bits_n = win_bits + WW'(1);
                    win_errs_n = win_errs + WW'(mismatch);
                    // Loss of lock outranks a window rollover on the same bit.
                    if (win_errs_n == WW'(LOSS_THR)) begin
                        state_n    = ST_LOAD;
                        load_cnt_n = '0;
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end else if (win_bits_n == WW'(WIN_LEN)) begin
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end
                end
                default: begin
                    state_n    = ST_LOAD;
                    load_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_LOAD;
            lfsr       <= '0;
            load_cnt   <= '0;
            verify_cnt <= '0;
            win_bits   <= '0;
            win_errs   <= '0;
            locked     <= 1'b0;
        end else begin
            if (consume) begin
                lfsr <= {lfsr[PRBS9_LEN-2:0], i_bit};
            end
            state      <= state_n;
            load_cnt   <= load_cnt_n;
            verify_cnt <= verify_cnt_n;
            win_bits   <= win_bits_n;
            win_errs   <= win_errs_n;
            locked     <= (state_n == ST_LOCKED);
        end
    end

    sat_counter #(.WIDTH(NB_COUNT)) u_bit_count (
        .clock  (clock),
        .reset  (reset),
        .clear  (i_clear),
        .enable (count_bit),
        .count  (o_bit_count)
    );

    sat_counter #(.WIDTH(NB_COUNT)) u_error_count (
        .clock  (clock),
        .reset  (reset),
        .clear  (i_clear),
        .enable (count_err),
        .count  (o_error_count)
    );

    assign o_locked   = locked;
    assign o_state    = state;
    assign o_ber_zero = locked && (o_error_count == '0) && (o_bit_count != '0);
endmodule
